audio_clk_gen: RTL

//  Parametrised audio serial clock generator: divides baseClk into a programmable
//  50%-duty bit clock (bclk) and a derived word/LR clock (lrclk) with per-edge strobes.

---
 rtl/audio_clk_gen_if.sv | 25 ++
 rtl/audio_clk_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/audio_clk_gen_if.sv
// Control and clock-output bundle for audio_clk_gen.
// The testbench or controller drives it as master, and the generator is the slave.
interface audio_clk_gen_if #(
  parameter int DIV_W = 8
);
  logic             enable;
  logic             divLoad;
  logic [DIV_W-1:0] divValue;
  logic             bclkOut;
  logic             bclkRise;
  logic             bclkFall;
  logic             lrclkOut;
  logic             frameStart;
  logic             divPending;

  modport master (
    output enable, divLoad, divValue,
    input  bclkOut, bclkRise, bclkFall, lrclkOut, frameStart, divPending
  );

  modport slave (
    input  enable, divLoad, divValue,
    output bclkOut, bclkRise, bclkFall, lrclkOut, frameStart, divPending
  );
endinterface

// File: rtl/audio_clk_gen.sv
// I2S-style bit/word clock generator: programmable 50% bclk, derived lrclk, per-edge strobes.
// A new divisor is applied only at a bclk falling boundary (or at once while frozen), so no phase is ever glitched.
module audio_clk_gen #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 4,
  parameter int SLOT_BITS   = 32
) (
  input  logic             baseClk,
  input  logic             resetN,
  audio_clk_gen_if.slave   bus
);
  localparam int SLOT_W = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic [DIV_W-1:0]  div_act_q, div_act_d;
  logic [DIV_W-1:0]  div_nxt_q, div_nxt_d;
  logic              pend_q, pend_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              frame_q, frame_d;

  logic              wrap, fall_edge, apply;
  logic [DIV_W-1:0]  div_sat;

  assign div_sat   = (bus.divValue == '0) ? DIV_W'(1) : bus.divValue;
  assign wrap      = (hcnt_q == div_act_q - DIV_W'(1));
  assign fall_edge = bus.enable && wrap && bclk_q;
  // When frozen, a pending divisor can take effect immediately because no phase is running.
  assign apply     = pend_q && (fall_edge || !bus.enable);

  always_comb begin
    hcnt_d    = hcnt_q;
    div_act_d = div_act_q;
    div_nxt_d = div_nxt_q;
    pend_d    = pend_q;
    slot_d    = slot_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    frame_d   = 1'b0;

    if (bus.enable) begin
      if (wrap) begin
        hcnt_d = '0;
        bclk_d = ~bclk_q;
        rise_d = ~bclk_q;
        fall_d = bclk_q;
      end else begin
        hcnt_d = hcnt_q + DIV_W'(1);
      end
      if (fall_edge) begin
        if (slot_q == SLOT_W'(SLOT_BITS - 1)) begin
          slot_d  = '0;
          lrclk_d = ~lrclk_q;
          frame_d = lrclk_q;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    end

    if (apply) begin
      div_act_d = div_nxt_q;
      hcnt_d    = '0;
      pend_d    = 1'b0;
    end

    // A load in the same cycle as an application stays pending for the next boundary.
    if (bus.divLoad) begin
      div_nxt_d = div_sat;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge baseClk or negedge resetN) begin
    if (!resetN) begin
      hcnt_q    <= '0;
      div_act_q <= DIV_W'(DIV_DEFAULT);
      div_nxt_q <= DIV_W'(DIV_DEFAULT);
      pend_q    <= 1'b0;
      slot_q    <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      div_act_q <= div_act_d;
      div_nxt_q <= div_nxt_d;
      pend_q    <= pend_d;
      slot_q    <= slot_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.bclkOut    = bclk_q;
  assign bus.bclkRise   = rise_q;
  assign bus.bclkFall   = fall_q;
  assign bus.lrclkOut   = lrclk_q;
  assign bus.frameStart = frame_q;
  assign bus.divPending = pend_q;
endmodule
